// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave: all five channels, with master and slave views.
interface axi4_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave with 16 x 32-bit registers; register 0 is a read-only ID.
// Define AXI4_LITE_REG_SLAVE_DECERR_EN to reject addresses above 0x3F with DECERR.
module axi4_lite_reg_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h4158_4C31
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axi4_lite_reg_slave_if.slave  bus
);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [31:0]           regs [16];
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    logic                  aw_fire, w_fire, have_aw, have_w;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic [3:0]            widx, ridx;
    logic                  w_inrange, r_inrange;
    logic [1:0]            wresp;

    // A beat arriving this cycle is used directly so AW and W may land together.
    always_comb begin
        aw_fire = bus.awvalid && bus.awready;
        w_fire  = bus.wvalid && bus.wready;
        have_aw = aw_held || aw_fire;
        have_w  = w_held || w_fire;
        waddr   = aw_held ? awaddr_q : bus.awaddr;
        wdata   = w_held ? wdata_q : bus.wdata;
        wstrb   = w_held ? wstrb_q : bus.wstrb;
        widx    = waddr[5:2];
        ridx    = bus.araddr[5:2];
`ifdef AXI4_LITE_REG_SLAVE_DECERR_EN
        w_inrange = (waddr[ADDR_WIDTH-1:6] == '0);
        r_inrange = (bus.araddr[ADDR_WIDTH-1:6] == '0);
`else
        w_inrange = 1'b1;
        r_inrange = 1'b1;
`endif
        if (!w_inrange)      wresp = DECERR;
        else if (widx == '0) wresp = SLVERR;
        else                 wresp = OKAY;
    end

    logic unused_ok;
    assign unused_ok = ^{bus.awprot, bus.arprot, waddr, bus.araddr};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_state     <= W_IDLE;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= OKAY;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (have_aw && have_w) begin
                        if (wresp == OKAY)
                            for (int b = 0; b < 4; b++)
                                if (wstrb[b]) regs[widx][8*b +: 8] <= wdata[8*b +: 8];
                        bus.bresp   <= wresp;
                        bus.bvalid  <= 1'b1;
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b0;
                        aw_held     <= 1'b0;
                        w_held      <= 1'b0;
                        w_state     <= W_RESP;
                    end else begin
                        if (aw_fire) begin
                            aw_held     <= 1'b1;
                            awaddr_q    <= bus.awaddr;
                            bus.awready <= 1'b0;
                        end
                        if (w_fire) begin
                            w_held     <= 1'b1;
                            wdata_q    <= bus.wdata;
                            wstrb_q    <= bus.wstrb;
                            bus.wready <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // regs is sampled before any same-edge write lands, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= R_IDLE;
            bus.arready <= 1'b1;
            bus.rvalid  <= 1'b0;
            bus.rresp   <= OKAY;
            bus.rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        if (!r_inrange) begin
                            bus.rdata <= '0;
                            bus.rresp <= DECERR;
                        end else begin
                            bus.rdata <= (ridx == '0) ? ID_VALUE : regs[ridx];
                            bus.rresp <= OKAY;
                        end
                        bus.rvalid  <= 1'b1;
                        bus.arready <= 1'b0;
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        bus.rvalid  <= 1'b0;
                        bus.arready <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed plus randomized bench for axi4_lite_reg_slave against an array-based register model.
module tb_axi4_lite_reg_slave;
    localparam logic [31:0] ID = 32'h4158_4C31;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] mregs [16];

    axi4_lite_reg_slave_if #(.ADDR_WIDTH(32)) bus ();

    axi4_lite_reg_slave #(.ADDR_WIDTH(32), .ID_VALUE(ID)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        idx = int'(a[5:2]);
`ifdef AXI4_LITE_REG_SLAVE_DECERR_EN
        if (a[31:6] != 0) return 2'b11;
`endif
        if (idx == 0) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
`ifdef AXI4_LITE_REG_SLAVE_DECERR_EN
        if (a[31:6] != 0) return {2'b11, 32'h0};
`endif
        if (a[5:2] == 4'd0) return {2'b00, ID};
        return {2'b00, mregs[a[5:2]]};
    endfunction

    task automatic idle_inputs();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.bready = 0;  bus.rready = 0;
        bus.awprot = 3'b000; bus.arprot = 3'b000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int bhold);
        int cyc; bit aw_done, w_done, aw_f, w_f;
        logic [1:0] exp_resp, got;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_dly) begin bus.awvalid = 1; bus.awaddr = addr; end
            if (!w_done && cyc >= w_dly) begin bus.wvalid = 1; bus.wdata = data; bus.wstrb = strb; end
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(posedge clk); #1; cyc++;
            if (aw_f) begin aw_done = 1; bus.awvalid = 0; end
            if (w_f)  begin w_done = 1;  bus.wvalid = 0;  end
            if (!(aw_done && w_done)) check("b_early", bus.bvalid, 0);
        end
        check("w_latency", cyc, ((aw_dly > w_dly) ? aw_dly : w_dly) + 1);
        exp_resp = model_write(addr, data, strb);
        check("bvalid", bus.bvalid, 1);
        check("bresp", bus.bresp, exp_resp);
        got = bus.bresp;
        repeat (bhold) begin
            @(posedge clk); #1;
            check("bvalid_hold", bus.bvalid, 1);
            check("bresp_hold", bus.bresp, got);
            check("awready_hold", bus.awready, 0);
            check("wready_hold", bus.wready, 0);
        end
        bus.bready = 1;
        @(posedge clk); #1;
        bus.bready = 0;
        check("bvalid_clr", bus.bvalid, 0);
        check("awready_ret", bus.awready, 1);
        check("wready_ret", bus.wready, 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rhold);
        int cyc; bit f;
        logic [33:0] exp;
        logic [31:0] d0;
        exp = model_read(addr);
        cyc = 0; f = 0;
        bus.arvalid = 1; bus.araddr = addr;
        while (!f && cyc < 20) begin
            f = bus.arready;
            @(posedge clk); #1; cyc++;
        end
        bus.arvalid = 0;
        check("ar_latency", cyc, 1);
        check("rvalid", bus.rvalid, 1);
        check("rdata", bus.rdata, exp[31:0]);
        check("rresp", bus.rresp, exp[33:32]);
        d0 = bus.rdata;
        repeat (rhold) begin
            @(posedge clk); #1;
            check("rvalid_hold", bus.rvalid, 1);
            check("rdata_hold", bus.rdata, d0);
            check("arready_hold", bus.arready, 0);
        end
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        check("rvalid_clr", bus.rvalid, 0);
        check("arready_ret", bus.arready, 1);
    endtask

    initial begin
        logic [33:0] pre;
        logic [31:0] hi, a;
        idle_inputs();
        bus.awaddr = 0; bus.wdata = 0; bus.wstrb = 0; bus.araddr = 0;
        model_reset();

        // reset state
        reset_n = 0;
        @(posedge clk); #1; @(posedge clk); #1;
        check("rst_awready", bus.awready, 1);
        check("rst_wready", bus.wready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rdata", bus.rdata, 0);
        reset_n = 1;
        @(posedge clk); #1;

        // AW and W together
        axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(32'h04, 0);
        check("reg1_value", bus.rdata, 32'hDEAD_BEEF);

        // W three cycles ahead of AW
        axi_write(32'h08, 32'h0000_00AA, 4'h1, 3, 0, 0);
        axi_read(32'h08, 0);
        // AW ahead of W
        axi_write(32'h0C, 32'hCAFE_F00D, 4'hF, 0, 2, 0);
        axi_read(32'h0C, 0);

        // read-only ID register
        axi_write(32'h00, 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_read(32'h00, 0);
        check("id_value", bus.rdata, ID);

        // first address past the register window
        axi_read(32'h40, 0);

        // byte lanes and empty strobe
        axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(32'h14, 32'h1122_3344, 4'b0101, 1, 0, 0);
        axi_read(32'h17, 0);
        axi_write(32'h14, 32'h0000_0000, 4'h0, 0, 0, 0);
        axi_read(32'h14, 0);

        // back-pressure on both response channels
        axi_write(32'h18, 32'h5A5A_A5A5, 4'hF, 0, 0, 5);
        axi_read(32'h18, 5);

        // write commit and read of the same register on one edge
        pre = model_read(32'h0C);
        bus.awvalid = 1; bus.awaddr = 32'h0C;
        bus.wvalid = 1;  bus.wdata = 32'h0BAD_CAFE; bus.wstrb = 4'hF;
        bus.arvalid = 1; bus.araddr = 32'h0C;
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        void'(model_write(32'h0C, 32'h0BAD_CAFE, 4'hF));
        check("coll_bvalid", bus.bvalid, 1);
        check("coll_rvalid", bus.rvalid, 1);
        check("coll_rdata_old", bus.rdata, pre[31:0]);
        bus.bready = 1; bus.rready = 1;
        @(posedge clk); #1;
        bus.bready = 0; bus.rready = 0;
        check("coll_bclr", bus.bvalid, 0);
        check("coll_rclr", bus.rvalid, 0);
        axi_read(32'h0C, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            hi = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            a = {hi[25:0], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2));
        end

        // reset while a write response is pending
        bus.awvalid = 1; bus.awaddr = 32'h14;
        bus.wvalid = 1;  bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0;
        check("pend_bvalid", bus.bvalid, 1);
        reset_n = 0;
        @(posedge clk); #1;
        check("mrst_bvalid", bus.bvalid, 0);
        check("mrst_awready", bus.awready, 1);
        check("mrst_wready", bus.wready, 1);
        check("mrst_arready", bus.arready, 1);
        check("mrst_rvalid", bus.rvalid, 0);
        reset_n = 1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 1; i < 16; i++) begin
            axi_read(32'(i * 4), 0);
            check("mrst_reg_zero", bus.rdata, 0);
        end

        // reset with only AW latched must not leave a stale address behind
        bus.awvalid = 1; bus.awaddr = 32'h1C;
        @(posedge clk); #1;
        bus.awvalid = 0;
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
        @(posedge clk); #1;
        axi_write(32'h20, 32'h2468_ACE0, 4'hF, 2, 0, 0);
        axi_read(32'h1C, 0);
        axi_read(32'h20, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of awaddr/araddr; legal range 8..32.
REQ-002 SHALL have parameter ID_VALUE, default 32'h4158_4C31: constant returned by register 0.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have ports awaddr in ADDR_WIDTH, awprot in 3 (ignored), awvalid in 1, awready out 1: write address channel.
REQ-006 SHALL have ports wdata in 32, wstrb in 4, wvalid in 1, wready out 1: write data channel.
REQ-007 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write response channel; bresp encoded OKAY=00, SLVERR=10, DECERR=11.
REQ-008 SHALL have ports araddr in ADDR_WIDTH, arprot in 3 (ignored), arvalid in 1, arready out 1: read address channel.
REQ-009 SHALL have ports rdata out 32, rresp out 2, rvalid out 1, rready in 1: read data channel; same rresp encoding.

Function
REQ-010 SHALL implement 16 x 32-bit registers; index = addr[5:2]; addr[1:0] ignored.
REQ-011 SHALL treat an address as in-range when addr[ADDR_WIDTH-1:6] == 0.
REQ-012 SHALL make register 0 read-only, always reading ID_VALUE; registers 1..15 read/write.
REQ-013 Write FSM SHALL have states W_IDLE and W_RESP.
REQ-014 In W_IDLE, awready SHALL be 1 until an AW beat is latched; wready SHALL be 1 until a W beat is latched; AW and W latch independently, in either order or in the same cycle.
REQ-015 On the edge where both AW and W are latched, SHALL commit the write, drive bresp, assert bvalid and enter W_RESP; awready = wready = 0 in W_RESP.
REQ-016 Write commit SHALL update only the byte lanes with wstrb[i]=1; wstrb=0000 SHALL be a no-op returning OKAY.
REQ-017 Write to register 0 SHALL modify nothing and return SLVERR; in-range write to 1..15 returns OKAY.
REQ-018 bvalid and bresp SHALL stay stable until bvalid&&bready; on that edge bvalid=0 and FSM returns to W_IDLE with AW/W latches cleared; minimum write turnaround 2 cycles.
REQ-019 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (arready=0).
REQ-020 On arvalid&&arready, SHALL register rdata/rresp and set rvalid=1 on the next edge (1-cycle latency); rdata/rresp/rvalid stable until rvalid&&rready, then return to R_IDLE.
REQ-021 Read and write channels SHALL operate concurrently; if a write commits on the same edge as an AR handshake to the same register, rdata SHALL be the pre-write value.
REQ-022 Valid/ready handshakes SHALL not depend combinationally on each other (all ready/valid outputs registered).

Reset
REQ-023 While reset_n=0 at a rising edge: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, registers 1..15 = 0, both FSMs idle, AW/W latches cleared.
REQ-024 Reset mid-transaction SHALL abandon pending B/R responses; no register write from an incomplete AW/W pair.

Configuration
REQ-025 Macro AXI4_LITE_REG_SLAVE_DECERR_EN: when defined, out-of-range reads return rdata=0, rresp=DECERR, and out-of-range writes modify nothing and return bresp=DECERR.
REQ-026 When not defined, range check SHALL be omitted: addresses alias by addr[5:2] and decode as in-range.

Verification
REQ-027 AW 0x04 and W 0xDEADBEEF/strb 1111 same cycle, bready=1 -> bvalid 1 cycle later, bresp=00; read 0x04 -> rdata=0xDEADBEEF, rresp=00.
REQ-028 W first (0x000000AA, strb 0001), AW 0x08 three cycles later -> bvalid after AW latch; read 0x08 -> 0x000000AA.
REQ-029 Write 0x12345678 to 0x00 -> bresp=10; read 0x00 -> 0x41584C31, rresp=00.
REQ-030 Read 0x40 with macro defined -> rresp=11, rdata=0; without macro -> aliases register 0, rdata=0x41584C31, rresp=00.
REQ-031 Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and data stable, awready/wready/arready=0 throughout.
REQ-032 Assert reset_n=0 while bvalid=1 -> next edge bvalid=0, all readies=1, registers 1..15 read 0.
